// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key map
// and the special-key positions.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_EMIT,
    ST_WAIT_RELEASE
  } kp_state_e;

  // Key positions are {row, col}.
  localparam logic [3:0] KEY_STAR = 4'd12;
  localparam logic [3:0] KEY_HASH = 4'd14;

  // Indexed by {row, col}; the '*' and '#' entries are never output.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [1:0] lowest_low(input logic [3:0] cols);
    logic [1:0] idx;
    casez (cols)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Consecutive-sample counter shared by press debounce and release detection.
// done is high in the cycle that completes CYCLES consecutive good samples.
module key_debounce #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic sample_ok,
  output logic done
);

  logic [7:0] cnt_q, cnt_d;

  assign done = !restart && sample_ok && (cnt_q == 8'(CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (!restart && sample_ok && !done) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner with debounce and one-cycle key pulses.
// Optional auto-repeat of held digit keys under `define KEYPAD_REPEAT_EN.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES   = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_CYCLES   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       enter,
  output logic       clear,
  output logic       key_busy
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || DEBOUNCE_CYCLES < 1 ||
      DEBOUNCE_CYCLES > 255 || REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_param
    $error("keypad_scan_ctrl: parameter out of range");
  end

  kp_state_e  state_q, state_d;
  logic [1:0] row_q, row_d;
  logic [1:0] col_q, col_d;
  logic [3:0] pat_q, pat_d;
  logic [3:0] settle_q, settle_d;
  logic [3:0] digit_q, digit_d;
  logic       dv_q, dv_d, enter_q, enter_d, clear_q, clear_d;
  logic       db_restart, db_ok, db_done;
  logic [3:0] key_idx;

`ifdef KEYPAD_REPEAT_EN
  logic [15:0] rep_q, rep_d;
`endif

  assign key_idx = {row_q, col_q};

  // Counter compares against the latched press pattern while debouncing,
  // and against all-released while waiting for release.
  assign db_restart = !(state_q == ST_DEBOUNCE || state_q == ST_WAIT_RELEASE);
  assign db_ok      = (state_q == ST_DEBOUNCE) ? (col_in == pat_q) : (col_in == 4'hF);

  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk       (clk),
    .rst_n     (rst),
    .restart   (db_restart),
    .sample_ok (db_ok),
    .done      (db_done)
  );

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    pat_d    = pat_q;
    settle_d = settle_q;
    digit_d  = digit_q;
    dv_d     = 1'b0;
    enter_d  = 1'b0;
    clear_d  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d    = rep_q;
`endif
    case (state_q)
      ST_SCAN: begin
        if (settle_q == 4'(SETTLE_CYCLES - 1)) begin
          settle_d = '0;
          if (col_in != 4'hF) begin
            pat_d   = col_in;
            col_d   = lowest_low(col_in);
            state_d = ST_DEBOUNCE;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      ST_DEBOUNCE: begin
        if (db_done) begin
          state_d = ST_EMIT;
          if (key_idx == KEY_STAR)      clear_d = 1'b1;
          else if (key_idx == KEY_HASH) enter_d = 1'b1;
          else begin
            dv_d    = 1'b1;
            digit_d = KEY_MAP[key_idx];
          end
        end else if (col_in != pat_q) begin
          state_d = ST_SCAN;
          row_d   = row_q + 2'd1;
        end
      end
      ST_EMIT: begin
        state_d = ST_WAIT_RELEASE;
`ifdef KEYPAD_REPEAT_EN
        rep_d = 16'd1;
`endif
      end
      default: begin
        if (db_done) begin
          state_d = ST_SCAN;
          row_d   = row_q + 2'd1;
        end
`ifdef KEYPAD_REPEAT_EN
        else if (key_idx != KEY_STAR && key_idx != KEY_HASH && col_in == pat_q) begin
          if (rep_q == 16'(REPEAT_CYCLES - 1)) begin
            rep_d = '0;
            dv_d  = 1'b1;
          end else begin
            rep_d = rep_q + 16'd1;
          end
        end else begin
          rep_d = 16'd1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_SCAN;
      row_q    <= '0;
      col_q    <= '0;
      pat_q    <= '1;
      settle_q <= '0;
      digit_q  <= '0;
      dv_q     <= 1'b0;
      enter_q  <= 1'b0;
      clear_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      pat_q    <= pat_d;
      settle_q <= settle_d;
      digit_q  <= digit_d;
      dv_q     <= dv_d;
      enter_q  <= enter_d;
      clear_q  <= clear_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q    <= rep_d;
`endif
    end
  end

  assign row_out     = ~(4'b0001 << row_q);
  assign digit       = digit_q;
  assign digit_valid = dv_q;
  assign enter       = enter_q;
  assign clear       = clear_q;
  assign key_busy    = (state_q != ST_SCAN);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: a keypad model answers row_out,
// directed presses queue expected pulses, a monitor checks each pulse.
module tb_keypad_scan_ctrl;

  localparam int DEB = 4;
  localparam int K_DIG = 0, K_ENT = 1, K_CLR = 2;

  typedef struct {
    int         kind;
    logic [3:0] dig;
  } exp_t;

  logic       clk, rst;
  logic [3:0] col_in, row_out, digit;
  logic       digit_valid, enter, clear, key_busy;
  logic [15:0] pressed;

  exp_t exp_q[$];
  int   checks, failures;
  int   cyc, rise_cyc;
  logic busy_prev;

  keypad_scan_ctrl #(.SETTLE_CYCLES(2), .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .col_in      (col_in),
    .row_out     (row_out),
    .digit       (digit),
    .digit_valid (digit_valid),
    .enter       (enter),
    .clear       (clear),
    .key_busy    (key_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row_out[r])
        for (int c = 0; c < 4; c++)
          if (pressed[r*4+c]) col_in[c] = 1'b0;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per output pulse.
  always @(negedge clk) begin
    if (!rst) begin
      busy_prev = 1'b0;
    end else begin
      cyc++;
      if (key_busy && !busy_prev) rise_cyc = cyc;
      busy_prev = key_busy;
      if (digit_valid || enter || clear) begin
        exp_t e;
        int   kind;
        kind = digit_valid ? K_DIG : (enter ? K_ENT : K_CLR);
        check("pulse_onehot", int'(digit_valid) + int'(enter) + int'(clear), 1);
        check("pulse_latency", cyc - rise_cyc, DEB);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse: got kind %0d digit %0h expected none", kind, digit);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", kind, e.kind);
          check("pulse_digit", int'(digit), int'(e.dig));
        end
      end
    end
  end

  task automatic wait_busy(input logic level);
    int n;
    n = 0;
    while (key_busy !== level && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (key_busy !== level) check("busy_timeout", int'(key_busy), int'(level));
  endtask

  task automatic press(input int idx, input int kind, input logic [3:0] dig, input int hold);
    exp_t e;
    e.kind = kind;
    e.dig  = dig;
    exp_q.push_back(e);
    @(negedge clk);
    pressed[idx] = 1'b1;
    repeat (hold) @(negedge clk);
    pressed[idx] = 1'b0;
    wait_busy(1'b0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; rise_cyc = 0; busy_prev = 1'b0;
    pressed = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_row_out", int'(row_out), 4'hE);
    check("rst_digit", int'(digit), 0);
    check("rst_pulses", int'(digit_valid) + int'(enter) + int'(clear), 0);
    check("rst_busy", int'(key_busy), 0);
    rst = 1'b1;

    // (1,2) -> 6, single pulse
    press(6, K_DIG, 4'h6, 20);
    check("digit_hold_6", int'(digit), 6);

    // 1,2,3,4 then '#' then '*'
    press(0, K_DIG, 4'h1, 20);
    press(1, K_DIG, 4'h2, 20);
    press(2, K_DIG, 4'h3, 20);
    press(4, K_DIG, 4'h4, 20);
    press(14, K_ENT, 4'h4, 20);
    press(12, K_CLR, 4'h4, 20);
    check("digit_after_star", int'(digit), 4);

    // Bouncing (0,0): never 4 stable samples
    for (int i = 0; i < 10; i++) begin
      pressed[0] = 1'b1;
      repeat (2) @(negedge clk);
      pressed[0] = 1'b0;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    check("bounce_busy_low", int'(key_busy), 0);
    check("bounce_digit", int'(digit), 4);

    // (0,1) and (0,3) together -> lowest column wins
    exp_q.push_back('{K_DIG, 4'h2});
    @(negedge clk);
    pressed[1] = 1'b1;
    pressed[3] = 1'b1;
    repeat (20) @(negedge clk);
    pressed[1] = 1'b0;
    pressed[3] = 1'b0;
    wait_busy(1'b0);
    repeat (3) @(negedge clk);

    // Hold '5', press '8' meanwhile: '8' only after '5' released
    exp_q.push_back('{K_DIG, 4'h5});
    exp_q.push_back('{K_DIG, 4'h8});
    pressed[5] = 1'b1;
    repeat (20) @(negedge clk);
    pressed[9] = 1'b1;
    repeat (10) @(negedge clk);
    check("other_row_ignored", int'(digit), 5);
    pressed[5] = 1'b0;
    repeat (30) @(negedge clk);
    pressed[9] = 1'b0;
    wait_busy(1'b0);
    repeat (3) @(negedge clk);
    check("digit_8", int'(digit), 8);

    // Reset during debounce of '5' discards the key
    pressed[5] = 1'b1;
    wait_busy(1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_row_out", int'(row_out), 4'hE);
    check("mid_rst_digit", int'(digit), 0);
    check("mid_rst_busy", int'(key_busy), 0);
    pressed[5] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("post_rst_digit", int'(digit), 0);
    check("post_rst_busy", int'(key_busy), 0);

    // Normal operation after reset
    press(15, K_DIG, 4'hD, 20);
    press(14, K_ENT, 4'hD, 20);
    press(13, K_DIG, 4'h0, 20);

    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: cycles each row is driven before its columns are sampled (legal range 1..15).
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive identical samples required to accept a press or a release (legal range 1..255).
REQ-003 Parameter REPEAT_CYCLES, default 64: hold time before auto-repeat; used only when KEYPAD_REPEAT_EN is defined.
REQ-004 clk  in  1  single system clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 col_in  in  4  keypad columns, active-low (pulled up); synchronous to clk.
REQ-007 row_out  out  4  keypad row drive, one-hot-low.
REQ-008 digit  out  4  code of the last accepted key; held stable between pulses.
REQ-009 digit_valid  out  1  one-cycle pulse when a digit key (0-9, A-D) is accepted.
REQ-010 enter  out  1  one-cycle pulse when '#' is accepted.
REQ-011 clear  out  1  one-cycle pulse when '*' is accepted.
REQ-012 key_busy  out  1  high in all states except SCAN.

Function
REQ-013 Key map (row,col):
- Row 0: 1, 2, 3, A.
- Row 1: 4, 5, 6, B.
- Row 2: 7, 8, 9, C.
- Row 3: *, 0, #, D.
- digit carries the hex value of the key; '*' and '#' leave digit unchanged.
REQ-014 FSM states: SCAN, DEBOUNCE, EMIT, WAIT_RELEASE.
REQ-015 SCAN: drive the current row low for SETTLE_CYCLES cycles, then sample col_in on the last settle cycle.
- Any column low: latch row and the lowest-index low column, go to DEBOUNCE.
- No column low: advance the row (3 wraps to 0) and restart settling.
REQ-016 DEBOUNCE: hold the row and count consecutive cycles with col_in equal to the latched pattern.
- DEBOUNCE_CYCLES matches: go to EMIT.
- Any mismatch: go to SCAN on the next row, with no output.
REQ-017 EMIT lasts exactly one cycle.
- Asserts exactly one of digit_valid, enter or clear.
- Updates digit in the same cycle as the pulse.
- Then goes to WAIT_RELEASE.
REQ-018 WAIT_RELEASE: hold the row until col_in reads 4'b1111 for DEBOUNCE_CYCLES consecutive cycles.
- Then go to SCAN on the next row.
- Any low column restarts the release count.
REQ-019 Latency: the pulse asserts exactly DEBOUNCE_CYCLES+1 cycles after the SCAN sample cycle that detected the key.
REQ-020 Simultaneous keys in one row: the lowest column wins. Keys in other rows are ignored until release.
REQ-021 At most one of digit_valid, enter and clear is high in any cycle.
REQ-022 A press is emitted at most once per press/release cycle, unless auto-repeat is enabled.

Reset
REQ-023 While rst is low, asynchronously force:
- state = SCAN, row index = 0, row_out = 4'b1110;
- digit = 4'h0; digit_valid = enter = clear = 0; key_busy = 0;
- all counters = 0.
REQ-024 Reset asserted mid-debounce or during EMIT discards the key; no pulse appears after reset release.
REQ-025 The first sample after reset release occurs SETTLE_CYCLES cycles after the first rising edge with rst high.

Configuration
REQ-026 With KEYPAD_REPEAT_EN defined, a digit key held in WAIT_RELEASE re-pulses digit_valid after REPEAT_CYCLES and then every REPEAT_CYCLES.
- '*' and '#' never repeat.
REQ-027 Without KEYPAD_REPEAT_EN, the repeat counter and REPEAT_CYCLES logic are absent and behaviour is exactly REQ-018.

Structure
REQ-028 Package keypad_pkg holds:
- the FSM state enum;
- KEY_STAR and KEY_HASH position constants;
- the 4x4 key-map constant table.
REQ-029 Sub-module key_debounce holds the match-or-release counter and is instantiated once, shared by DEBOUNCE and WAIT_RELEASE.
REQ-030 The outputs connect directly to the door lock's digit, digit_valid and enter inputs with no glue logic.

Verification
REQ-031 Parameters are defaults (2/4/64) unless stated.
REQ-032 Press (1,2) for 20 cycles, then release -> digit=4'h6 with one digit_valid pulse, 5 cycles after detection; no second pulse.
REQ-033 Press sequence 1,2,3,4 then '#' -> digit_valid pulses carry 1,2,3,4 in order, then one enter pulse; clear stays 0.
REQ-034 Bounce col0 low 2 cycles, high 1 cycle, repeated 10 times in row 0 -> no pulse and key_busy returns low.
REQ-035 Hold (0,1) and (0,3) together -> one pulse with digit=4'h2.
REQ-036 Assert rst for 3 cycles during DEBOUNCE of '5' -> after reset: row_out=4'b1110, digit=0, no pulse.
REQ-037 With KEYPAD_REPEAT_EN, hold '7' for 200 cycles -> 4 digit_valid pulses (at emit, +64, +128, +192 cycles).
